// File: rtl/tap_sum_sequencer_pkg.sv
// Shared constants for the three-tap sum sequencer: datapath width, tap count,
// adder block size and FSM state encodings.
package tap_sum_sequencer_pkg;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned TAPS      = 3;
  localparam int unsigned ADD_BLOCK = 4;
  localparam int unsigned STATE_W   = 2;

  // FSM state encodings
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_ADD1 = 2'd1;
  localparam logic [STATE_W-1:0] ST_ADD2 = 2'd2;
  localparam logic [STATE_W-1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/tap_sum_sequencer_if.sv
// Sample-in / result-out valid-ready bus of the tap sum sequencer.
//   in_valid/in_data/in_ready     : sample source -> sequencer
//   out_valid/out_data/out_ovf    : sequencer -> output stage
//   out_ready                     : output stage accepts result
// master = source/consumer side, slave = sequencer side.
interface tap_sum_sequencer_if
  import tap_sum_sequencer_pkg::*;
;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/carryskipadder.sv
// Combinational carry-skip adder: ripple-carry blocks of BLOCK bits, with the
// block carry bypassing the ripple chain when every bit of the block propagates.
//   a_i, b_i : operands
//   cin_i    : carry in
//   sum_o    : a_i + b_i + cin_i (mod 2^WIDTH)
//   cout_o   : carry out of the MSB
module carryskipadder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gen;

  assign prop = a_i ^ b_i;
  assign gen  = a_i & b_i;

  // Ripple inside each block; block carry-out skips when the block fully propagates
  always_comb begin : csa
    logic [NBLK:0] blk_c;
    logic          rc;
    sum_o    = '0;
    blk_c    = '0;
    blk_c[0] = cin_i;
    for (int blk = 0; blk < int'(NBLK); blk++) begin
      rc = blk_c[blk];
      for (int i = 0; i < int'(BLOCK); i++) begin
        sum_o[blk*BLOCK+i] = prop[blk*BLOCK+i] ^ rc;
        rc = gen[blk*BLOCK+i] | (prop[blk*BLOCK+i] & rc);
      end
      blk_c[blk+1] = (&prop[blk*BLOCK +: BLOCK]) ? blk_c[blk] : rc;
    end
    cout_o = blk_c[NBLK];
  end

endmodule

// File: rtl/tap_sum_sequencer.sv
// Time-multiplexed three-tap sum: y[n] = x[n] + x[n-1] + x[n-2] (mod 2^16)
// computed over two cycles on one shared carry-skip adder, with a sticky
// carry-out flag per result.
//   clk, rst : clock, synchronous active-high reset
//   clear    : synchronous flush of delay line and in-flight operation
//   tap_en   : per-tap enable, latched on sample acceptance
//   busy     : sequencer not idle
//   bus      : sample in / result out valid-ready bus (slave side)
module tap_sum_sequencer
  import tap_sum_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [TAPS-1:0] tap_en,
  output logic            busy,
  tap_sum_sequencer_if.slave bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [TAPS-1:0]    en_q, en_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;

  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic               add_cout;

  // The single adder of this block
  carryskipadder #(
    .WIDTH (WIDTH),
    .BLOCK (ADD_BLOCK)
  ) u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Next-state, delay line and adder operand selection
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    en_d        = en_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    add_a       = '0;
    add_b       = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x2_d    = x1_q;
          x1_d    = x0_q;
          x0_d    = bus.in_data;
          en_d    = tap_en;
          state_d = ST_ADD1;
        end
      end
      ST_ADD1: begin
        add_a     = en_q[0] ? x0_q : '0;
        add_b     = en_q[1] ? x1_q : '0;
        acc_d     = add_sum;
        ovf_acc_d = add_cout;
        state_d   = ST_ADD2;
      end
      ST_ADD2: begin
        add_a       = acc_q;
        add_b       = en_q[2] ? x2_q : '0;
        out_data_d  = add_sum;
        out_ovf_d   = ovf_acc_q | add_cout;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over any acceptance or handshake in the same cycle
    if (clear) begin
      x0_d        = '0;
      x1_d        = '0;
      x2_d        = '0;
      acc_d       = '0;
      ovf_acc_d   = 1'b0;
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      en_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Ready and busy are decoded straight from the state register
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
